// File: rtl/gray_pkg.sv
// gray_pkg: shared default widths and gray/binary conversion helpers
//   GRAY_W    - default code word width
//   ERR_CNT_W - default step-error counter width
//   gray2bin / bin2gray - 32-bit conversions; narrower words zero-extend safely
package gray_pkg;
  localparam int GRAY_W = 8;
  localparam int ERR_CNT_W = 16;
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
    return b;
  endfunction
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/gray_step_chk.sv
// gray_step_chk: flags samples that are not exactly one bit away from the previous valid sample
//   i_clk, i_rst_n - clock, synchronous active-low reset
//   i_vld, i_gray  - stage-1 sample and its qualifier
//   i_clr          - drop history; a coincident sample is left unchecked and becomes the new history
//   o_step_err     - combinational error flag for the current sample
module gray_step_chk
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vld,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_gray,
  output logic             o_step_err
);
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] diff;
  logic             have_prev;
  always_comb begin
    diff = i_gray ^ prev_gray;
    // distance is 1 only when diff is a nonzero power of two
    o_step_err = i_vld && have_prev && !i_clr && ((diff == '0) || ((diff & (diff - WIDTH'(1))) != '0));
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      prev_gray <= '0;
      have_prev <= 1'b0;
    end else if (i_vld) begin
      prev_gray <= i_gray;
      have_prev <= 1'b1;
    end else if (i_clr) begin
      have_prev <= 1'b0;
    end
endmodule

// File: rtl/gray2bin_decoder.sv
// gray2bin_decoder: 2-cycle gray-to-binary decoder with unit-distance step checking
//   i_clk, i_rst_n - clock, synchronous active-low reset
//   i_en, i_gray   - input sample and qualifier
//   i_clr_err      - clears the error counter and step history
//   o_vld, o_bin   - decoded word, i_en delayed 2 cycles; o_bin holds while idle
//   o_step_err     - step error for the word on o_bin, 0 when o_vld=0
//   o_err_cnt      - saturating count of step errors
module gray2bin_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W,
  parameter int CNT_W = ERR_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_gray,
  input  logic             i_clr_err,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_bin,
  output logic             o_step_err,
  output logic [CNT_W-1:0] o_err_cnt
);
  logic             en_q;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin_d;
  logic             step_err;
  always_comb
    for (int i = 0; i < WIDTH; i++) bin_d[i] = ^(gray_q >> i);
  gray_step_chk #(.WIDTH(WIDTH)) u_chk (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_vld      (en_q),
    .i_clr      (i_clr_err),
    .i_gray     (gray_q),
    .o_step_err (step_err)
  );
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      en_q       <= 1'b0;
      gray_q     <= '0;
      o_vld      <= 1'b0;
      o_bin      <= '0;
      o_step_err <= 1'b0;
      o_err_cnt  <= '0;
    end else begin
      en_q       <= i_en;
      gray_q     <= i_gray;
      o_vld      <= en_q;
      o_step_err <= step_err;
      if (en_q) o_bin <= bin_d;
      o_err_cnt  <= i_clr_err ? '0 :
                    (o_vld && o_step_err && !(&o_err_cnt)) ? o_err_cnt + CNT_W'(1) : o_err_cnt;
    end
endmodule

// File: doc/gray2bin_decoder.md
GRAY2BIN_DECODER -- requirements
Module: gray2bin_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width in bits of both code words (gray and binary).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the step-error counter.
REQ-003 The block SHALL have port i_clk, input, 1 bit, the system clock (all logic on its rising edge).
REQ-004 The block SHALL have port i_rst_n, input, 1 bit, the reset: synchronous, active-low.
REQ-005 The block SHALL have port i_en, input, 1 bit, qualifying i_gray as a valid sample this cycle.
REQ-006 The block SHALL have port i_gray, input, WIDTH bits, the gray-coded input word.
REQ-007 The block SHALL have port i_clr_err, input, 1 bit, a synchronous clear of the error counter and step history.
REQ-008 The block SHALL have port o_vld, output, 1 bit, qualifying o_bin and o_step_err.
REQ-009 The block SHALL have port o_bin, output, WIDTH bits, the decoded binary word.
REQ-010 The block SHALL have port o_step_err, output, 1 bit, flagging that the current sample is not unit-distance from the previous valid sample.
REQ-011 The block SHALL have port o_err_cnt, output, CNT_W bits, the saturating count of step errors.

Function
REQ-012 Stage 1 SHALL register i_gray and i_en unconditionally every cycle.
REQ-013 Stage 2 SHALL compute binary from the stage-1 word and register it: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1] XOR g[i], for i descending.
REQ-014 Total latency SHALL be exactly 2 cycles, i_en/i_gray at edge N -> o_vld/o_bin at edge N+2, so that the block cascades directly behind the 2-cycle binary-to-gray encoder.
REQ-015 o_vld SHALL be i_en delayed 2 cycles, and SHALL assert for one cycle per valid input with no bubbles for back-to-back inputs.
REQ-016 o_bin SHALL hold its last value while o_vld=0.
REQ-017 The step checker SHALL keep prev_gray and have_prev, updated only on stage-1 valid samples.
REQ-018 For a valid sample with have_prev=1, the checker SHALL set step_err=1 when popcount(sample XOR prev_gray) is not equal to 1; a repeated word (distance 0) is also an error.
REQ-019 The first valid sample after reset or after a clear SHALL produce step_err=0 and SHALL set have_prev=1.
REQ-020 Wrap-around gray words 0x80 -> 0x00 (WIDTH=8) SHALL be treated as distance 1, i.e. no error.
REQ-021 Gaps in i_en SHALL NOT clear the history; the comparison is always against the last valid sample.
REQ-022 o_step_err SHALL be registered alongside o_bin, aligned with o_vld, and SHALL be 0 whenever o_vld=0.
REQ-023 o_err_cnt SHALL increment by 1 on each cycle where o_vld=1 and o_step_err=1.
REQ-024 o_err_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-025 i_clr_err SHALL set o_err_cnt=0 and have_prev=0 on the next edge.
REQ-026 i_clr_err SHALL override a simultaneous increment; the data pipeline is unaffected.
REQ-027 i_clr_err coincident with a stage-1 valid sample SHALL leave that sample un-checked, and that sample SHALL become the new prev_gray (have_prev=1).

Reset
REQ-028 Reset SHALL take effect on the first rising edge of i_clk while i_rst_n=0, for all registers.
REQ-029 During and after reset, outputs SHALL be o_vld=0, o_bin=0, o_step_err=0 and o_err_cnt=0, and internal state SHALL be have_prev=0 and prev_gray=0.
REQ-030 Reset mid-stream SHALL drop all in-flight samples; no o_vld pulse SHALL emerge for inputs accepted in the 2 cycles before reset.

Structure
REQ-031 Package gray_pkg SHALL hold the default WIDTH and CNT_W constants and a gray-to-binary function shared with the encoder-side testbench model.
REQ-032 One sub-module, gray_step_chk, SHALL hold prev_gray/have_prev and the popcount==1 test, outputting step_err per valid sample.
REQ-033 The decode logic SHALL be inline in gray2bin_decoder.
REQ-034 The block SHALL instantiate no vendor primitives or memories.

Verification
REQ-035 The bench SHALL check reset: hold i_rst_n=0 for 3 cycles with i_en=1 -> o_vld=0, o_bin=0x00, o_err_cnt=0 throughout.
REQ-036 The bench SHALL check a full sweep: feed the 2-cycle encoder with binary 0..255 contiguously (i_en=1) -> o_bin equals 0..255 in order, 2 cycles after each gray input, with o_step_err=0 and o_err_cnt=0, including the 0x80->0x00 wrap.
REQ-037 The bench SHALL check error detection: gray sequence 0x00, 0x01, 0x07, 0x07 -> o_step_err = 0, 0, 1, 1 and o_err_cnt ends at 2; o_bin = 0x00, 0x01, 0x05, 0x05.
REQ-038 The bench SHALL check gaps and clear: valid 0x03, idle 5 cycles, valid 0x02 -> no error; then pulse i_clr_err, valid 0xFF -> no error and o_err_cnt=0.
REQ-039 The bench SHALL check saturation with CNT_W=4: feed 20 consecutive 0x00 words -> o_err_cnt reaches 0xF and holds.
REQ-040 The bench SHALL check reset mid-stream: i_en=1 on edges 10-11, i_rst_n=0 at edge 12 -> no o_vld at edges 12-13.
